// File: rtl/fir_pkg.sv
// fir_pkg: shared scaling helpers and constants for FIR post-processing stages
package fir_pkg;
   localparam int DROP_CNT_W = 8;
   function automatic logic [31:0] fir_round_sat(input logic [31:0] sum, input int s, input int width);
      logic [32:0] r;
      r = ({1'b0, sum} + (33'd1 << (s - 1))) >> s;
      return (r > ((33'd1 << width) - 33'd1)) ? ((32'd1 << width) - 32'd1) : r[31:0];
   endfunction
endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: synchronous FIFO, wrap-bit pointers, combinational head read
module fir_sync_fifo #(
   parameter int dw = 4,
   parameter int depth = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [dw-1:0]            push_data,
   input  logic                     pop,
   output logic [dw-1:0]            rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(depth):0]   count,
   output logic                     push_ok
);
   localparam int aw = $clog2(depth);
   logic [aw:0]   rd, wr;
   logic [dw-1:0] mem [depth];
   logic          pop_ok;
   always_comb begin
      empty   = rd == wr;
      full    = (rd[aw] != wr[aw]) && (rd[aw-1:0] == wr[aw-1:0]);
      count   = wr - rd;
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      rd_data = mem[rd[aw-1:0]];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rd <= '0;
         wr <= '0;
      end else begin
         if (push_ok) wr <= wr + 1'b1;
         if (pop_ok) rd <= rd + 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (push_ok) mem[wr[aw-1:0]] <= push_data;
endmodule

// File: rtl/fir_avg_out.sv
// fir_avg_out: moving-sum to rounded/saturated average, buffered with drop accounting
module fir_avg_out
   import fir_pkg::*;
#(
   parameter int tapSize = 4,
   parameter int width = 4,
   parameter int depth = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   input  logic [$clog2(tapSize)+width-1:0]  in,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [width-1:0]                  out,
   output logic [$clog2(depth):0]            count,
   output logic                              overflow,
   output logic [DROP_CNT_W-1:0]             drop_count
);
   localparam int S = $clog2(tapSize);
   if ((tapSize < 2) || ((tapSize & (tapSize - 1)) != 0) || (depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_param
      $error("fir_avg_out: tapSize and depth must be powers of two >= 2");
   end
   logic [width-1:0] avg_q;
   logic             avg_v_q, empty, full, push_ok;
   always_ff @(posedge clk) begin
      if (reset) begin
         avg_v_q <= 1'b0;
         avg_q   <= '0;
      end else begin
         avg_v_q <= in_valid;
         if (in_valid) avg_q <= width'(fir_round_sat(32'(in), S, width));
      end
   end
   assign out_valid = ~empty;
   fir_sync_fifo #(.dw(width), .depth(depth)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(avg_v_q),
      .push_data(avg_q),
      .pop(out_valid & out_ready),
      .rd_data(out),
      .empty(empty),
      .full(full),
      .count(count),
      .push_ok(push_ok)
   );
   // rejected pushes only; full is implied by !push_ok while avg_v_q is set
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (avg_v_q && !push_ok) begin
         overflow <= 1'b1;
         if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_fir_avg_out.sv
// tb_fir_avg_out: directed table-driven check of averaging, FIFO and drop accounting
module tb_fir_avg_out;
   typedef struct {
      logic       rst;
      logic       v;
      logic [5:0] din;
      logic       rdy;
      logic       ev;
      logic [3:0] eo;
      logic [2:0] ec;
      logic       eovf;
      logic [7:0] edrop;
   } vec_t;
   logic       clk = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [5:0] in_s = '0;
   logic       out_valid, overflow;
   logic [3:0] out_s;
   logic [2:0] count;
   logic [7:0] drop_count;
   int         n_chk = 0, n_fail = 0;
   vec_t       tbl[$];
   fir_avg_out #(.tapSize(4), .width(4), .depth(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_s),
      .out_valid(out_valid), .out_ready(out_ready), .out(out_s),
      .count(count), .overflow(overflow), .drop_count(drop_count)
   );
   always #5 clk = ~clk;
   task automatic check(input string nm, input int idx, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask
   task automatic add(input logic rst, v, input int din, input logic rdy, ev, input int eo, ec, input logic eovf, input int edrop);
      vec_t t;
      t.rst = rst; t.v = v; t.din = 6'(din); t.rdy = rdy; t.ev = ev;
      t.eo = 4'(eo); t.ec = 3'(ec); t.eovf = eovf; t.edrop = 8'(edrop);
      tbl.push_back(t);
   endtask
   task automatic drive(input logic rst, v, input int din, input logic rdy);
      reset = rst; in_valid = v; in_s = 6'(din); out_ready = rdy;
      @(posedge clk);
      #1;
   endtask
   initial begin
      // reset
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // rounding: 13,2,1,0 -> 3,1,0,0
      add(0, 1, 13, 1, 0, 0, 0, 0, 0);
      add(0, 1, 2, 1, 1, 3, 1, 0, 0);
      add(0, 1, 1, 1, 1, 1, 1, 0, 0);
      add(0, 1, 0, 1, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // saturation: 63,62 -> 15,15
      add(0, 1, 63, 1, 0, 0, 0, 0, 0);
      add(0, 1, 62, 1, 1, 15, 1, 0, 0);
      add(0, 0, 0, 1, 1, 15, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // fill 1..5 with stalled consumer, fifth dropped, then drain
      add(0, 1, 4, 0, 0, 0, 0, 0, 0);
      add(0, 1, 8, 0, 1, 1, 1, 0, 0);
      add(0, 1, 12, 0, 1, 1, 2, 0, 0);
      add(0, 1, 16, 0, 1, 1, 3, 0, 0);
      add(0, 1, 20, 0, 1, 1, 4, 0, 0);
      add(0, 0, 0, 0, 1, 1, 4, 1, 1);
      add(0, 0, 0, 1, 1, 2, 3, 1, 1);
      add(0, 0, 0, 1, 1, 3, 2, 1, 1);
      add(0, 0, 0, 1, 1, 4, 1, 1, 1);
      add(0, 0, 0, 1, 0, 0, 0, 1, 1);
      // full with simultaneous push/pop
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 4, 0, 0, 0, 0, 0, 0);
      add(0, 1, 8, 0, 1, 1, 1, 0, 0);
      add(0, 1, 12, 0, 1, 1, 2, 0, 0);
      add(0, 1, 16, 0, 1, 1, 3, 0, 0);
      add(0, 1, 20, 0, 1, 1, 4, 0, 0);
      add(0, 1, 24, 1, 1, 2, 4, 0, 0);
      add(0, 1, 28, 1, 1, 3, 4, 0, 0);
      add(0, 1, 32, 1, 1, 4, 4, 0, 0);
      add(0, 0, 0, 1, 1, 5, 4, 0, 0);
      add(0, 0, 0, 0, 1, 5, 4, 0, 0);
      add(0, 0, 0, 1, 1, 6, 3, 0, 0);
      add(0, 0, 0, 1, 1, 7, 2, 0, 0);
      add(0, 0, 0, 1, 1, 8, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].v, int'(tbl[i].din), tbl[i].rdy);
         check("out_valid", i, int'(out_valid), int'(tbl[i].ev));
         check("count", i, int'(count), int'(tbl[i].ec));
         check("overflow", i, int'(overflow), int'(tbl[i].eovf));
         check("drop_count", i, int'(drop_count), int'(tbl[i].edrop));
         if (tbl[i].ev) check("out", i, int'(out_s), int'(tbl[i].eo));
      end
      // drop counter saturation: 295 rejected pushes must stop at 255
      drive(1, 0, 0, 0);
      for (int k = 0; k < 300; k++) drive(0, 1, 8, 0);
      check("sat_drop", 0, int'(drop_count), 255);
      check("sat_count", 0, int'(count), 4);
      check("sat_ovf", 0, int'(overflow), 1);
      check("sat_out", 0, int'(out_s), 2);
      drive(0, 0, 0, 1);
      check("sat_pp_count", 0, int'(count), 4);
      drive(0, 0, 0, 1);
      check("pre_rst_count", 0, int'(count), 3);
      // reset mid-stream with a sample presented during reset
      drive(1, 1, 40, 0);
      check("mid_rst_valid", 0, int'(out_valid), 0);
      check("mid_rst_count", 0, int'(count), 0);
      check("mid_rst_ovf", 0, int'(overflow), 0);
      check("mid_rst_drop", 0, int'(drop_count), 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1);
         check("post_rst_valid", k, int'(out_valid), 0);
      end
      drive(0, 1, 20, 1);
      check("restart_lat", 0, int'(out_valid), 0);
      drive(0, 0, 0, 1);
      check("restart_valid", 0, int'(out_valid), 1);
      check("restart_out", 0, int'(out_s), 5);
      drive(0, 0, 0, 1);
      check("restart_empty", 0, int'(out_valid), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
